// File: rtl/hc_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : hc_csr_bank
// Brief    : HardCloud MMIO CSR bank: DSM base, control FSM, N buffer
//            descriptors, 1-cycle read responses. Optional readback mux is
//            enabled by defining HC_CSR_READBACK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hc_csr_bank #(
   parameter int          HC_BUFFER_SIZE = 3,
   parameter logic [15:0] HC_BUF_BASE    = 16'h120,
   parameter logic [15:0] HC_CTRL_ADDR   = 16'h118,
   parameter logic [15:0] HC_DSM_ADDR    = 16'h110
) (
   input  logic                         clk,
   input  logic                         reset,
   // c0 MMIO request (hdr.address is a DWORD address)
   input  logic [15:0]                  rx_mmio_addr,
   input  logic [8:0]                   rx_mmio_tid,
   input  logic [63:0]                  rx_mmio_data,
   input  logic                         rx_mmio_wr_valid,
   input  logic                         rx_mmio_rd_valid,
   // c2 MMIO read response
   output logic [8:0]                   tx_mmio_tid,
   output logic [63:0]                  tx_mmio_data,
   output logic                         tx_mmio_rd_valid,
   output logic [63:0]                  dsm_base,
   output logic [HC_BUFFER_SIZE*42-1:0] buf_addr,
   output logic [HC_BUFFER_SIZE*32-1:0] buf_size,
   output logic [HC_BUFFER_SIZE-1:0]    buf_valid,
   output logic                         afu_reset,
   output logic                         start,
   output logic                         running,
   input  logic                         done
);

   localparam logic [2:0] S_RST  = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_RUN  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_STOP = 3'd4;

   localparam logic [31:0] c_CMD_ASSERT_RST = 32'h0;
   localparam logic [31:0] c_CMD_DEASSERT   = 32'h1;
   localparam logic [31:0] c_CMD_START      = 32'h3;
   localparam logic [31:0] c_CMD_STOP       = 32'h7;

   localparam logic [15:0] c_DSM_DW     = HC_DSM_ADDR >> 2;
   localparam logic [15:0] c_CTRL_DW    = HC_CTRL_ADDR >> 2;
   localparam logic [15:0] c_BUF_DW     = HC_BUF_BASE >> 2;
   localparam logic [15:0] c_BUF_END_DW = c_BUF_DW + 16'(4 * HC_BUFFER_SIZE);
   localparam int          c_IDX_W      = (HC_BUFFER_SIZE > 1) ? $clog2(HC_BUFFER_SIZE) : 1;

   logic [2:0]  state_q, state_d;
   logic        start_q, start_d;
   logic [63:0] dsm_base_q, dsm_base_d;
   logic [41:0] buf_addr_q [HC_BUFFER_SIZE];
   logic [41:0] buf_addr_d [HC_BUFFER_SIZE];
   logic [31:0] buf_size_q [HC_BUFFER_SIZE];
   logic [31:0] buf_size_d [HC_BUFFER_SIZE];
   logic [HC_BUFFER_SIZE-1:0] buf_valid_q, buf_valid_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [8:0]  rsp_tid_q, rsp_tid_d;
   logic [63:0] rsp_data_q, rsp_data_d;

   logic               w_dsm_hit;
   logic               w_ctrl_wr;
   logic               w_buf_hit;
   logic [15:0]        w_buf_off;
   logic [c_IDX_W-1:0] w_buf_idx;
   logic               w_reg_wr;
   logic               w_assert_rst;
   logic [31:0]        w_cmd;
   logic [63:0]        w_rd_data;

   // ---------------------------------------------------------------------
   // Address decode; the descriptor window check bounds the index to N-1
   // ---------------------------------------------------------------------
   always_comb begin
      w_dsm_hit    = (rx_mmio_addr == c_DSM_DW);
      w_buf_off    = rx_mmio_addr - c_BUF_DW;
      w_buf_idx    = c_IDX_W'(w_buf_off >> 2);
      w_buf_hit    = !rx_mmio_addr[0] && (rx_mmio_addr >= c_BUF_DW) &&
                     (rx_mmio_addr < c_BUF_END_DW);
      w_cmd        = rx_mmio_data[31:0];
      w_ctrl_wr    = rx_mmio_wr_valid && (rx_mmio_addr == c_CTRL_DW);
      w_assert_rst = w_ctrl_wr && (w_cmd == c_CMD_ASSERT_RST);
      w_reg_wr     = rx_mmio_wr_valid && (state_q != S_RUN);
   end

   // ---------------------------------------------------------------------
   // Register file next-state
   // ---------------------------------------------------------------------
   always_comb begin
      dsm_base_d  = dsm_base_q;
      buf_addr_d  = buf_addr_q;
      buf_size_d  = buf_size_q;
      buf_valid_d = buf_valid_q;
      if (w_reg_wr && w_dsm_hit) begin
         dsm_base_d = rx_mmio_data;
      end
      if (w_reg_wr && w_buf_hit) begin
         if (rx_mmio_addr[1]) begin
            buf_size_d[w_buf_idx]  = rx_mmio_data[31:0];
            buf_valid_d[w_buf_idx] = 1'b1;
         end else begin
            buf_addr_d[w_buf_idx] = rx_mmio_data[41:0];
         end
      end
      if (w_assert_rst) begin
         dsm_base_d  = '0;
         buf_valid_d = '0;
      end
   end

   // ---------------------------------------------------------------------
   // Control FSM: state register / next-state / outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_RST;
         start_q <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (w_assert_rst) begin
         state_d = S_RST;
      end else begin
         case (state_q)
            S_RST: begin
               if (w_ctrl_wr && (w_cmd == c_CMD_DEASSERT)) state_d = S_IDLE;
            end
            S_IDLE, S_DONE, S_STOP: begin
               if (w_ctrl_wr && (w_cmd == c_CMD_START)) state_d = S_RUN;
            end
            S_RUN: begin
               // a STOP command outranks a simultaneous completion
               if (w_ctrl_wr && (w_cmd == c_CMD_STOP)) state_d = S_STOP;
               else if (done)                          state_d = S_DONE;
            end
            default: state_d = S_RST;
         endcase
      end
      start_d = (state_d == S_RUN) && (state_q != S_RUN);
   end

   always_comb begin
      afu_reset = (state_q == S_RST);
      running   = (state_q == S_RUN);
      start     = start_q;
   end

   // ---------------------------------------------------------------------
   // Read data mux (sampled from pre-write register values)
   // ---------------------------------------------------------------------
`ifdef HC_CSR_READBACK_EN
   always_comb begin
      w_rd_data = '0;
      if (w_dsm_hit) begin
         w_rd_data = dsm_base_q;
      end else if (rx_mmio_addr == c_CTRL_DW) begin
         w_rd_data = {61'b0, state_q};
      end else if (w_buf_hit) begin
         w_rd_data = rx_mmio_addr[1] ? {32'b0, buf_size_q[w_buf_idx]}
                                     : {22'b0, buf_addr_q[w_buf_idx]};
      end
   end
`else
   always_comb begin
      w_rd_data = '0;
   end
`endif

   always_comb begin
      rsp_valid_d = rx_mmio_rd_valid;
      rsp_tid_d   = rx_mmio_rd_valid ? rx_mmio_tid : 9'd0;
      rsp_data_d  = rx_mmio_rd_valid ? w_rd_data : 64'd0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         dsm_base_q  <= '0;
         buf_valid_q <= '0;
         rsp_valid_q <= 1'b0;
         rsp_tid_q   <= '0;
         rsp_data_q  <= '0;
         for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
            buf_addr_q[i] <= '0;
            buf_size_q[i] <= '0;
         end
      end else begin
         dsm_base_q  <= dsm_base_d;
         buf_valid_q <= buf_valid_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_tid_q   <= rsp_tid_d;
         rsp_data_q  <= rsp_data_d;
         for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
            buf_addr_q[i] <= buf_addr_d[i];
            buf_size_q[i] <= buf_size_d[i];
         end
      end
   end

   generate
      for (genvar g = 0; g < HC_BUFFER_SIZE; g++) begin : g_buf_out
         assign buf_addr[g*42 +: 42] = buf_addr_q[g];
         assign buf_size[g*32 +: 32] = buf_size_q[g];
      end
   endgenerate

   assign dsm_base         = dsm_base_q;
   assign buf_valid        = buf_valid_q;
   assign tx_mmio_rd_valid = rsp_valid_q;
   assign tx_mmio_tid      = rsp_tid_q;
   assign tx_mmio_data     = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_hc_csr_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_hc_csr_bank
// Brief    : Directed self-checking bench for hc_csr_bank (either build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hc_csr_bank;

`ifdef HC_CSR_READBACK_EN
   localparam bit c_RB = 1'b1;
`else
   localparam bit c_RB = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic [15:0]   rx_mmio_addr;
   logic [8:0]    rx_mmio_tid;
   logic [63:0]   rx_mmio_data;
   logic          rx_mmio_wr_valid;
   logic          rx_mmio_rd_valid;
   logic [8:0]    tx_mmio_tid;
   logic [63:0]   tx_mmio_data;
   logic          tx_mmio_rd_valid;
   logic [63:0]   dsm_base;
   logic [125:0]  buf_addr;
   logic [95:0]   buf_size;
   logic [2:0]    buf_valid;
   logic          afu_reset;
   logic          start;
   logic          running;
   logic          done;

   int n_pass  = 0;
   int n_total = 0;

   hc_csr_bank #(
      .HC_BUFFER_SIZE (3),
      .HC_BUF_BASE    (16'h120),
      .HC_CTRL_ADDR   (16'h118),
      .HC_DSM_ADDR    (16'h110)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .rx_mmio_addr     (rx_mmio_addr),
      .rx_mmio_tid      (rx_mmio_tid),
      .rx_mmio_data     (rx_mmio_data),
      .rx_mmio_wr_valid (rx_mmio_wr_valid),
      .rx_mmio_rd_valid (rx_mmio_rd_valid),
      .tx_mmio_tid      (tx_mmio_tid),
      .tx_mmio_data     (tx_mmio_data),
      .tx_mmio_rd_valid (tx_mmio_rd_valid),
      .dsm_base         (dsm_base),
      .buf_addr         (buf_addr),
      .buf_size         (buf_size),
      .buf_valid        (buf_valid),
      .afu_reset        (afu_reset),
      .start            (start),
      .running          (running),
      .done             (done)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout observed=no-finish expected=finish");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Write is sampled on the posedge between the two negedges
   task automatic mmio_wr(input logic [15:0] byte_addr, input logic [63:0] data);
      @(negedge clk);
      rx_mmio_addr     = byte_addr >> 2;
      rx_mmio_data     = data;
      rx_mmio_wr_valid = 1'b1;
      @(negedge clk);
      rx_mmio_wr_valid = 1'b0;
   endtask

   task automatic mmio_rd(input string tag, input logic [15:0] byte_addr, input logic [8:0] tid,
                          input logic [63:0] exp_data);
      @(negedge clk);
      rx_mmio_addr     = byte_addr >> 2;
      rx_mmio_tid      = tid;
      rx_mmio_rd_valid = 1'b1;
      @(negedge clk);
      rx_mmio_rd_valid = 1'b0;
      check({tag, "_valid"}, {63'b0, tx_mmio_rd_valid}, 64'd1);
      check({tag, "_tid"}, {55'b0, tx_mmio_tid}, {55'b0, tid});
      check({tag, "_data"}, tx_mmio_data, exp_data);
   endtask

   initial begin
      reset            = 1'b1;
      rx_mmio_addr     = '0;
      rx_mmio_tid      = '0;
      rx_mmio_data     = '0;
      rx_mmio_wr_valid = 1'b0;
      rx_mmio_rd_valid = 1'b0;
      done             = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      // 1: reset state
      check("rst_afu_reset", {63'b0, afu_reset}, 64'd1);
      check("rst_running", {63'b0, running}, 64'd0);
      check("rst_start", {63'b0, start}, 64'd0);
      check("rst_buf_valid", {61'b0, buf_valid}, 64'd0);
      check("rst_dsm", dsm_base, 64'd0);
      check("rst_tx_valid", {63'b0, tx_mmio_rd_valid}, 64'd0);
      mmio_rd("t1_status", 16'h118, 9'h1A, 64'd0);
      @(negedge clk);
      check("t1_single_rsp", {63'b0, tx_mmio_rd_valid}, 64'd0);

      // 2: deassert, program buffer 1 and DSM
      mmio_wr(16'h118, 64'd1);
      check("t2_afu_reset", {63'b0, afu_reset}, 64'd0);
      check("t2_state_idle", {61'b0, dut.state_q}, 64'd1);
      mmio_wr(16'h130, 64'h123);
      mmio_wr(16'h138, 64'h400);
      mmio_wr(16'h110, 64'hDEAD_BEEF_0000_1000);
      check("t2_buf_valid", {61'b0, buf_valid}, 64'h2);
      check("t2_buf_addr1", {22'b0, buf_addr[83:42]}, 64'h123);
      check("t2_buf_size1", {32'b0, buf_size[63:32]}, 64'h400);
      check("t2_buf_addr0", {22'b0, buf_addr[41:0]}, 64'h0);
      check("t2_dsm", dsm_base, 64'hDEAD_BEEF_0000_1000);
      mmio_rd("t2_rd_size1", 16'h138, 9'h003, c_RB ? 64'h400 : 64'h0);
      mmio_rd("t2_rd_dsm", 16'h110, 9'h004, c_RB ? 64'hDEAD_BEEF_0000_1000 : 64'h0);
      mmio_rd("t2_rd_status", 16'h118, 9'h1FF, c_RB ? 64'd1 : 64'd0);

      // 3: START pulse and write lock
      mmio_wr(16'h118, 64'd3);
      check("t3_start_hi", {63'b0, start}, 64'd1);
      check("t3_running", {63'b0, running}, 64'd1);
      @(negedge clk);
      check("t3_start_lo", {63'b0, start}, 64'd0);
      mmio_wr(16'h120, 64'hAAA);
      mmio_wr(16'h110, 64'h55);
      check("t3_locked_addr0", {22'b0, buf_addr[41:0]}, 64'h0);
      check("t3_locked_dsm", dsm_base, 64'hDEAD_BEEF_0000_1000);
      check("t3_still_run", {63'b0, running}, 64'd1);

      // 4: done and STOP together -> STOP
      @(negedge clk);
      rx_mmio_addr     = 16'h118 >> 2;
      rx_mmio_data     = 64'd7;
      rx_mmio_wr_valid = 1'b1;
      done             = 1'b1;
      @(negedge clk);
      rx_mmio_wr_valid = 1'b0;
      done             = 1'b0;
      check("t4_state_stop", {61'b0, dut.state_q}, 64'd4);
      check("t4_running", {63'b0, running}, 64'd0);
      mmio_rd("t4_rd_status", 16'h118, 9'h010, c_RB ? 64'd4 : 64'd0);

      // done alone -> S_DONE
      mmio_wr(16'h118, 64'd3);
      check("t4_restart", {63'b0, running}, 64'd1);
      @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      check("t4_state_done", {61'b0, dut.state_q}, 64'd3);

      // 5: out-of-range descriptor, back-to-back reads
      mmio_wr(16'h150, 64'h555);
      mmio_wr(16'h158, 64'h777);
      check("t5_oor_valid", {61'b0, buf_valid}, 64'h2);
      check("t5_oor_addr1", {22'b0, buf_addr[83:42]}, 64'h123);
      check("t5_oor_addr2", {22'b0, buf_addr[125:84]}, 64'h0);
      check("t5_oor_size2", {32'b0, buf_size[95:64]}, 64'h0);
      mmio_rd("t5_rd_oor", 16'h150, 9'h007, 64'd0);
      @(negedge clk);
      rx_mmio_addr     = 16'h130 >> 2;
      rx_mmio_tid      = 9'd5;
      rx_mmio_rd_valid = 1'b1;
      @(negedge clk);
      rx_mmio_addr     = 16'h138 >> 2;
      rx_mmio_tid      = 9'd6;
      check("t5_b2b0_valid", {63'b0, tx_mmio_rd_valid}, 64'd1);
      check("t5_b2b0_tid", {55'b0, tx_mmio_tid}, 64'd5);
      check("t5_b2b0_data", tx_mmio_data, c_RB ? 64'h123 : 64'h0);
      @(negedge clk);
      rx_mmio_rd_valid = 1'b0;
      check("t5_b2b1_valid", {63'b0, tx_mmio_rd_valid}, 64'd1);
      check("t5_b2b1_tid", {55'b0, tx_mmio_tid}, 64'd6);
      check("t5_b2b1_data", tx_mmio_data, c_RB ? 64'h400 : 64'h0);
      @(negedge clk);
      check("t5_b2b_end", {63'b0, tx_mmio_rd_valid}, 64'd0);

      // read and write to the same register in one cycle -> pre-write value
      @(negedge clk);
      rx_mmio_addr     = 16'h138 >> 2;
      rx_mmio_data     = 64'h800;
      rx_mmio_tid      = 9'd9;
      rx_mmio_wr_valid = 1'b1;
      rx_mmio_rd_valid = 1'b1;
      @(negedge clk);
      rx_mmio_wr_valid = 1'b0;
      rx_mmio_rd_valid = 1'b0;
      check("t5_rw_data", tx_mmio_data, c_RB ? 64'h400 : 64'h0);
      check("t5_rw_size", {32'b0, buf_size[63:32]}, 64'h800);

      // 6: ASSERT_RST from S_RUN
      mmio_wr(16'h118, 64'd3);
      check("t6_running", {63'b0, running}, 64'd1);
      mmio_wr(16'h118, 64'd0);
      check("t6_afu_reset", {63'b0, afu_reset}, 64'd1);
      check("t6_buf_valid", {61'b0, buf_valid}, 64'd0);
      check("t6_dsm", dsm_base, 64'd0);
      check("t6_running_lo", {63'b0, running}, 64'd0);
      check("t6_addr_kept", {22'b0, buf_addr[83:42]}, 64'h123);

      // START is ignored in S_RST; unknown code ignored after DEASSERT
      mmio_wr(16'h118, 64'd3);
      check("t6_start_in_rst", {61'b0, dut.state_q}, 64'd0);
      mmio_wr(16'h118, 64'd1);
      mmio_wr(16'h118, 64'd5);
      check("t6_unknown_cmd", {61'b0, dut.state_q}, 64'd1);
      mmio_wr(16'h118, 64'd7);
      check("t6_stop_in_idle", {61'b0, dut.state_q}, 64'd1);
      mmio_rd("t6_rd_status", 16'h118, 9'h0AB, c_RB ? 64'd1 : 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
